// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared encodings for the MEM-stage load/store unit
// Purpose: access-size encodings, FSM state type and the full-word lane mask
//          used by mem_access_unit and mau_lane_align.
// Ports: none (package).
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] FULL_MASK = 4'b1111;

  typedef enum logic {
    IDLE,
    RMW_WR
  } mau_state_t;

endpackage

// File: rtl/mau_lane_align.sv
// rtl/mau_lane_align.sv - byte/half lane extract+extend for loads, lane merge for stores
// Purpose: purely combinational lane handling for 32-bit words.
// Ports:
//   size      in  2   access size (SZ_B/SZ_H, anything else is a full word)
//   sign_ext  in  1   loads: 1 sign-extend, 0 zero-extend
//   lane      in  2   byte offset inside the word (already alignment-adjusted)
//   rdata     in  32  word read from memory
//   wdata     in  32  store data, low bytes used for byte/half
//   load_data out 32  extended load result
//   merged    out 32  rdata with the store lane replaced by wdata
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = rdata[{lane, 3'b000} +: 8];
  assign half_val = rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rdata;
    merged    = wdata;
    case (size)
      SZ_B: begin
        load_data = {{24{sign_ext & byte_val[7]}}, byte_val};
        merged    = rdata;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = {{16{sign_ext & half_val[15]}}, half_val};
        merged    = rdata;
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data = rdata;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit in front of the data memory
// Purpose: accepts one load/store per handshake, drives memory pins combinationally,
//          returns extended load data one cycle later, and does read-modify-write
//          for byte/half stores because the memory only writes whole words.
// Optional feature: MAU_MISALIGN_TRAP_EN - trap misaligned half/word accesses
//          instead of forcing natural alignment.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/req_ready       request handshake from EX
//   req_we/size/signed/addr/wdata/rd   request fields
//   mem_ce/we/rr/addr/wdata/w_mask/r_mask, mem_rdata   data memory interface
//   wb_valid/wb_rd/wb_data    registered load result to WB
//   exc_valid/exc_addr        registered misaligned-access trap
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              mem_rr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_w_mask,
  output logic [3:0]        mem_r_mask,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              exc_valid,
  output logic [ADDR_W-1:0] exc_addr
);

  mau_state_t        state_q, state_d;
  logic [ADDR_W-1:0] rmw_addr_q;
  logic [DATA_W-1:0] rmw_data_q;
  logic [ADDR_W-1:0] eff_addr;
  logic              misaligned;
  logic              is_word;
  logic              accept;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  // Reserved size 2'b11 behaves as a word.
  assign is_word = (req_size != SZ_B) && (req_size != SZ_H);

`ifdef MAU_MISALIGN_TRAP_EN
  assign eff_addr   = req_addr;
  assign misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                      (is_word && (req_addr[1:0] != 2'b00));
`else
  always_comb begin
    eff_addr = req_addr;
    if (req_size == SZ_H) eff_addr[0]   = 1'b0;
    else if (is_word)     eff_addr[1:0] = 2'b00;
  end
  assign misaligned = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign mem_w_mask = FULL_MASK;
  assign mem_r_mask = FULL_MASK;

  mau_lane_align u_lane (
    .size      (req_size),
    .sign_ext  (req_signed),
    .lane      (eff_addr[1:0]),
    .rdata     (mem_rdata),
    .wdata     (req_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_rr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (accept && !misaligned) begin
          mem_ce   = 1'b1;
          mem_addr = {eff_addr[ADDR_W-1:2], 2'b00};
          if (req_we && is_word) begin
            mem_we    = 1'b1;
            mem_wdata = req_wdata;
          end else begin
            // Loads and the read half of a sub-word store.
            mem_rr = 1'b1;
            if (req_we) state_d = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = rmw_addr_q;
        mem_wdata = rmw_data_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_addr_q <= '0;
      rmw_data_q <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      wb_valid <= accept && !req_we && !misaligned;
      if (accept && !req_we && !misaligned) begin
        wb_rd   <= req_rd;
        wb_data <= load_data;
      end
      if (accept && req_we && !is_word && !misaligned) begin
        rmw_addr_q <= {eff_addr[ADDR_W-1:2], 2'b00};
        rmw_data_q <= merged;
      end
    end
  end

`ifdef MAU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_valid <= 1'b0;
      exc_addr  <= '0;
    end else begin
      exc_valid <= accept && misaligned;
      if (accept && misaligned) exc_addr <= req_addr;
    end
  end
`else
  assign exc_valid = 1'b0;
  assign exc_addr  = '0;
`endif

endmodule
